// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - fetch stage: PC owner, imem address driver, 2-entry {pc, instr} queue
//
// Ports:
//   fetch_clk, fetch_rst_n      clock, asynchronous active-low reset
//   fetch_imem_addr             word index into instruction memory (pc[IMEM_ADDR_WIDTH+1:2])
//   fetch_imem_data             registered memory read data, valid one cycle after the address
//   fetch_out_valid/ready       decode handshake; fetch_out_instr/fetch_out_pc are the queue head
//   fetch_redirect_valid/pc     branch/jump redirect; flushes queue and in-flight fetch
//   fetch_misaligned            sticky flag for a redirect target with pc[1:0] != 0 (fetch halted)
//   fetch_cnt_issued/stall      performance counters, present only with FETCH_PERF_CNT_EN defined
module instruction_fetch #(
    parameter int                  PC_WIDTH        = 32,
    parameter int                  IMEM_ADDR_WIDTH = 5,
    parameter logic [PC_WIDTH-1:0] RESET_PC        = 32'h0000_0000
) (
    input  logic                       fetch_clk,
    input  logic                       fetch_rst_n,
    output logic [IMEM_ADDR_WIDTH-1:0] fetch_imem_addr,
    input  logic [31:0]                fetch_imem_data,
    output logic                       fetch_out_valid,
    input  logic                       fetch_out_ready,
    output logic [31:0]                fetch_out_instr,
    output logic [PC_WIDTH-1:0]        fetch_out_pc,
    input  logic                       fetch_redirect_valid,
    input  logic [PC_WIDTH-1:0]        fetch_redirect_pc,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0]                fetch_cnt_issued,
    output logic [31:0]                fetch_cnt_stall,
`endif
    output logic                       fetch_misaligned
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_HALT
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [PC_WIDTH-1:0] pc;
    logic [PC_WIDTH-1:0] inflight_pc;
    logic                inflight;
    logic [31:0]         q0_instr;
    logic [31:0]         q1_instr;
    logic [PC_WIDTH-1:0] q0_pc;
    logic [PC_WIDTH-1:0] q1_pc;
    logic [1:0]          count;
    logic                misaligned;

    logic                pop;
    logic                push;
    logic                issue;
    logic [2:0]          occupancy;
    logic [2:0]          limit;

    assign pop       = (count != 2'd0) && fetch_out_ready;
    // A response whose fetch is overtaken by a redirect is dropped, never queued.
    assign push      = inflight && !fetch_redirect_valid;
    assign occupancy = {1'b0, count} + {2'b00, inflight};
    // A pop in this cycle frees a slot, which keeps throughput at one per cycle.
    assign limit     = pop ? 3'd3 : 3'd2;
    assign issue     = (state == S_RUN) && !fetch_redirect_valid && (occupancy < limit);

    assign fetch_imem_addr  = pc[IMEM_ADDR_WIDTH+1:2];
    assign fetch_out_valid  = (count != 2'd0);
    assign fetch_out_instr  = q0_instr;
    assign fetch_out_pc     = q0_pc;
    assign fetch_misaligned = misaligned;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  state_nxt = S_RUN;
            S_RUN:   state_nxt = S_RUN;
            S_HALT:  state_nxt = S_HALT;
            default: state_nxt = S_IDLE;
        endcase
        if (fetch_redirect_valid) begin
            state_nxt = (fetch_redirect_pc[1:0] != 2'b00) ? S_HALT : S_RUN;
        end
    end

    always_ff @(posedge fetch_clk or negedge fetch_rst_n) begin
        if (!fetch_rst_n) begin
            state       <= S_IDLE;
            pc          <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
            q0_instr    <= '0;
            q1_instr    <= '0;
            q0_pc       <= '0;
            q1_pc       <= '0;
            count       <= 2'd0;
            misaligned  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (fetch_redirect_valid) begin
                pc         <= fetch_redirect_pc;
                inflight   <= 1'b0;
                count      <= 2'd0;
                misaligned <= (fetch_redirect_pc[1:0] != 2'b00);
            end else begin
                inflight <= issue;
                if (issue) begin
                    pc          <= pc + PC_WIDTH'(4);
                    inflight_pc <= pc;
                end
                // Shift-register queue: q0 is always the head.
                case ({push, pop})
                    2'b10: begin
                        if (count == 2'd0) begin
                            q0_instr <= fetch_imem_data;
                            q0_pc    <= inflight_pc;
                        end else begin
                            q1_instr <= fetch_imem_data;
                            q1_pc    <= inflight_pc;
                        end
                        count <= count + 2'd1;
                    end
                    2'b01: begin
                        q0_instr <= q1_instr;
                        q0_pc    <= q1_pc;
                        count    <= count - 2'd1;
                    end
                    2'b11: begin
                        if (count == 2'd2) begin
                            q0_instr <= q1_instr;
                            q0_pc    <= q1_pc;
                            q1_instr <= fetch_imem_data;
                            q1_pc    <= inflight_pc;
                        end else begin
                            q0_instr <= fetch_imem_data;
                            q0_pc    <= inflight_pc;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge fetch_clk or negedge fetch_rst_n) begin
        if (!fetch_rst_n) begin
            fetch_cnt_issued <= 32'd0;
            fetch_cnt_stall  <= 32'd0;
        end else begin
            if (issue) begin
                fetch_cnt_issued <= fetch_cnt_issued + 32'd1;
            end
            if ((state == S_RUN) && fetch_out_valid && !fetch_out_ready) begin
                fetch_cnt_stall <= fetch_cnt_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - self-checking bench for instruction_fetch
module tb_instruction_fetch;

    logic        clk;
    logic        rst_n;
    logic [4:0]  imem_addr;
    logic [31:0] imem_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        misaligned;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] cnt_issued;
    logic [31:0] cnt_stall;
`endif

    int checks;
    int failures;

    instruction_fetch dut (
        .fetch_clk            (clk),
        .fetch_rst_n          (rst_n),
        .fetch_imem_addr      (imem_addr),
        .fetch_imem_data      (imem_data),
        .fetch_out_valid      (out_valid),
        .fetch_out_ready      (out_ready),
        .fetch_out_instr      (out_instr),
        .fetch_out_pc         (out_pc),
        .fetch_redirect_valid (redirect_valid),
        .fetch_redirect_pc    (redirect_pc),
`ifdef FETCH_PERF_CNT_EN
        .fetch_cnt_issued     (cnt_issued),
        .fetch_cnt_stall      (cnt_stall),
`endif
        .fetch_misaligned     (misaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 32-word instruction memory with one-cycle registered read.
    logic [31:0] mem [32];
    always @(posedge clk) imem_data <= mem[imem_addr];

    function automatic logic [31:0] word_of(logic [31:0] pc);
        return 32'hC0DE_0000 | {27'd0, pc[6:2]};
    endfunction

    typedef struct {
        bit          rst;
        bit          rdy;
        bit          rv;
        logic [31:0] rpc;
        bit          ev;
        logic [31:0] epc;
        logic [4:0]  ea;
        bit          em;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(bit rst, bit rdy, bit rv, logic [31:0] rpc,
                                bit ev, logic [31:0] epc, logic [4:0] ea, bit em);
        vec_t v;
        v.rst = rst; v.rdy = rdy; v.rv = rv; v.rpc = rpc;
        v.ev = ev; v.epc = epc; v.ea = ea; v.em = em;
        vecs.push_back(v);
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        for (int i = 0; i < 32; i++) mem[i] = 32'hC0DE_0000 | i;
        rst_n          = 1'b0;
        out_ready      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;

        // A: ready held high, 1 instr/cycle after 3-cycle latency.
        add(1,1,0,0, 0,32'h00,0,0);
        add(0,1,0,0, 0,32'h00,0,0);
        add(0,1,0,0, 0,32'h00,1,0);
        add(0,1,0,0, 1,32'h00,2,0);
        add(0,1,0,0, 1,32'h04,3,0);
        add(0,1,0,0, 1,32'h08,4,0);
        add(0,1,0,0, 1,32'h0C,5,0);
        // B: back-pressure fills the queue, address frozen, head stable.
        add(1,0,0,0, 0,32'h00,0,0);
        add(0,0,0,0, 0,32'h00,0,0);
        add(0,0,0,0, 0,32'h00,1,0);
        add(0,0,0,0, 1,32'h00,2,0);
        for (int i = 0; i < 4; i++) add(0,0,0,0, 1,32'h00,2,0);
        add(0,1,0,0, 1,32'h00,2,0);
        add(0,1,0,0, 1,32'h04,3,0);
        add(0,1,0,0, 1,32'h08,4,0);
        // C: redirect with queued 0x8 and in-flight 0xC.
        add(1,1,0,0, 0,32'h00,0,0);
        add(0,1,0,0, 0,32'h00,0,0);
        add(0,1,0,0, 0,32'h00,1,0);
        add(0,1,0,0, 1,32'h00,2,0);
        add(0,1,0,0, 1,32'h04,3,0);
        add(0,0,1,32'h40, 1,32'h08,4,0);
        add(0,1,0,0, 0,32'h00,16,0);
        add(0,1,0,0, 0,32'h00,17,0);
        add(0,1,0,0, 1,32'h40,18,0);
        add(0,1,0,0, 1,32'h44,19,0);
        // D: misaligned redirect halts fetch for 10 cycles, then aligned redirect resumes.
        add(0,1,1,32'h42, 1,32'h48,20,0);
        for (int i = 0; i < 10; i++) add(0,1,0,0, 0,32'h00,16,1);
        add(0,1,1,32'h10, 0,32'h00,16,1);
        add(0,1,0,0, 0,32'h00,4,0);
        add(0,1,0,0, 0,32'h00,5,0);
        add(0,1,0,0, 1,32'h10,6,0);
        // E: address wraps at memory end, pc keeps counting.
        add(0,1,1,32'h7C, 1,32'h14,7,0);
        add(0,1,0,0, 0,32'h00,31,0);
        add(0,1,0,0, 0,32'h00,0,0);
        add(0,1,0,0, 1,32'h7C,1,0);
        add(0,1,0,0, 1,32'h80,2,0);

        @(negedge clk);
        @(negedge clk);
        chk("reset_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_addr", {27'd0, imem_addr}, 32'd0);
        chk("reset_instr", out_instr, 32'd0);
        chk("reset_pc", out_pc, 32'd0);
        chk("reset_misaligned", {31'd0, misaligned}, 32'd0);
`ifdef FETCH_PERF_CNT_EN
        chk("reset_cnt_issued", cnt_issued, 32'd0);
        chk("reset_cnt_stall", cnt_stall, 32'd0);
`endif

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].rst) begin
                rst_n = 1'b0;
                @(negedge clk);
                @(negedge clk);
                rst_n = 1'b1;
            end
            out_ready      = vecs[i].rdy;
            redirect_valid = vecs[i].rv;
            redirect_pc    = vecs[i].rpc;
            chk($sformatf("row%0d_valid", i), {31'd0, out_valid}, {31'd0, vecs[i].ev});
            chk($sformatf("row%0d_addr", i), {27'd0, imem_addr}, {27'd0, vecs[i].ea});
            chk($sformatf("row%0d_misaligned", i), {31'd0, misaligned}, {31'd0, vecs[i].em});
            if (vecs[i].ev) begin
                chk($sformatf("row%0d_pc", i), out_pc, vecs[i].epc);
                chk($sformatf("row%0d_instr", i), out_instr, word_of(vecs[i].epc));
            end
            @(negedge clk);
        end

        // Asynchronous reset between edges while halted on a misaligned target.
        out_ready      = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h42;
        @(negedge clk);
        redirect_valid = 1'b0;
        chk("halt_misaligned", {31'd0, misaligned}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_valid", {31'd0, out_valid}, 32'd0);
        chk("async_instr", out_instr, 32'd0);
        chk("async_pc", out_pc, 32'd0);
        chk("async_addr", {27'd0, imem_addr}, 32'd0);
        chk("async_misaligned", {31'd0, misaligned}, 32'd0);
`ifdef FETCH_PERF_CNT_EN
        chk("async_cnt_issued", cnt_issued, 32'd0);
        chk("async_cnt_stall", cnt_stall, 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        begin
            int lat;
            lat = -1;
            for (int c = 0; c < 10; c++) begin
                if (out_valid) begin
                    lat = c;
                    break;
                end
                @(negedge clk);
            end
            chk("restart_latency", lat, 32'd3);
            chk("restart_pc", out_pc, 32'd0);
            chk("restart_instr", out_instr, word_of(32'd0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
